// File: rtl/tmds_pkg.sv
// rtl/tmds_pkg.sv - shared TMDS symbol constants and decoder state encoding
package tmds_pkg;

  localparam int SYM_W = 10;

  localparam logic [SYM_W-1:0] CTRL_TOK_00 = 10'b1101010100;
  localparam logic [SYM_W-1:0] CTRL_TOK_01 = 10'b0010101011;
  localparam logic [SYM_W-1:0] CTRL_TOK_10 = 10'b0101010100;
  localparam logic [SYM_W-1:0] CTRL_TOK_11 = 10'b1010101011;

  typedef enum logic [1:0] {
    SEARCH = 2'd0,
    SLIP   = 2'd1,
    LOCKED = 2'd2
  } tmds_state_e;

endpackage

// File: rtl/tmds_symbol_decode.sv
// rtl/tmds_symbol_decode.sv - combinational TMDS symbol classifier and 8b/10b data decoder
module tmds_symbol_decode
  import tmds_pkg::*;
(
  input  logic [SYM_W-1:0] i_sym,
  output logic             o_is_ctrl,
  output logic [1:0]       o_c,
  output logic [7:0]       o_data
);

  logic [7:0] w_q;

  // Match the four control tokens; anything else is treated as a data symbol
  always_comb begin
    o_is_ctrl = 1'b1;
    o_c       = 2'b00;
    case (i_sym)
      CTRL_TOK_00: o_c = 2'b00;
      CTRL_TOK_01: o_c = 2'b01;
      CTRL_TOK_10: o_c = 2'b10;
      CTRL_TOK_11: o_c = 2'b11;
      default:     o_is_ctrl = 1'b0;
    endcase
  end

  // Bit 9 marks an inverted payload
  assign w_q = i_sym[9] ? ~i_sym[7:0] : i_sym[7:0];

  // Undo the XOR (bit 8 set) or XNOR (bit 8 clear) transition chain
  always_comb begin
    o_data[0] = w_q[0];
    for (int i = 1; i < 8; i++) begin
      o_data[i] = i_sym[8] ? (w_q[i] ^ w_q[i-1]) : ~(w_q[i] ^ w_q[i-1]);
    end
  end

endmodule

// File: rtl/tmds_decoder.sv
// rtl/tmds_decoder.sv - one TMDS receive channel: token alignment, decode, lock tracking (optional TMDS_DECODER_LOSSCNT_EN)
module tmds_decoder
  import tmds_pkg::*;
#(
  parameter int LOCK_COUNT    = 8,
  parameter int SEARCH_WINDOW = 1024,
  parameter int LOSS_WINDOW   = 2048
) (
  input  logic             clk_25mhz,
  input  logic             rst,
  input  logic [SYM_W-1:0] raw_in,
  output logic [7:0]       data,
  output logic [1:0]       c,
  output logic             de,
  output logic             valid,
  output logic             locked,
  output logic [3:0]       offset
`ifdef TMDS_DECODER_LOSSCNT_EN
  ,
  output logic [15:0]      lock_loss_cnt
`endif
);

  localparam int HIT_W  = $clog2(LOCK_COUNT + 1);
  localparam int WIN_W  = $clog2(SEARCH_WINDOW);
  localparam int LOSS_W = $clog2(LOSS_WINDOW);

  localparam logic [HIT_W-1:0]  HIT_LAST  = HIT_W'(LOCK_COUNT - 1);
  localparam logic [HIT_W-1:0]  HIT_MAX   = HIT_W'(LOCK_COUNT);
  localparam logic [WIN_W-1:0]  WIN_LAST  = WIN_W'(SEARCH_WINDOW - 1);
  localparam logic [LOSS_W-1:0] LOSS_LAST = LOSS_W'(LOSS_WINDOW - 1);

  tmds_state_e r_state, w_state_nxt;

  logic [2*SYM_W-1:0] r_hist;
  logic [3:0]         r_offset;
  logic [HIT_W-1:0]   r_hit_cnt;
  logic [WIN_W-1:0]   r_win_cnt;
  logic [LOSS_W-1:0]  r_loss_cnt;
  logic [7:0]         r_data;
  logic [1:0]         r_c;
  logic               r_de;
  logic               r_valid;

  logic [2*SYM_W-1:0] w_hist_shift;
  logic [SYM_W-1:0]   w_sym;
  logic [SYM_W-1:0]   w_unused_shift_hi;
  logic               w_is_ctrl;
  logic [1:0]         w_dec_c;
  logic [7:0]         w_dec_data;
  logic [7:0]         w_data_nxt;
  logic [1:0]         w_c_nxt;
  logic               w_de_nxt;
  logic               w_valid_nxt;

  // Offset never exceeds 9, so the top half of the shifted history is never a symbol
  assign w_hist_shift      = r_hist >> r_offset;
  assign w_sym             = w_hist_shift[SYM_W-1:0];
  assign w_unused_shift_hi = w_hist_shift[2*SYM_W-1:SYM_W];

  tmds_symbol_decode u_sym_dec (
    .i_sym     (w_sym),
    .o_is_ctrl (w_is_ctrl),
    .o_c       (w_dec_c),
    .o_data    (w_dec_data)
  );

  // State register
  always_ff @(posedge clk_25mhz or negedge rst) begin
    if (!rst) r_state <= SEARCH;
    else      r_state <= w_state_nxt;
  end

  // Next state: lock takes priority over a window expiry on the same cycle
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      SEARCH: begin
        if (w_is_ctrl && (r_hit_cnt == HIT_LAST)) w_state_nxt = LOCKED;
        else if (r_win_cnt == WIN_LAST)           w_state_nxt = SLIP;
      end
      SLIP:    w_state_nxt = SEARCH;
      LOCKED: begin
        if (!w_is_ctrl && (r_loss_cnt == LOSS_LAST)) w_state_nxt = SLIP;
      end
      default: w_state_nxt = SEARCH;
    endcase
  end

  // Output values for the next cycle; c holds across data symbols while locked
  always_comb begin
    w_valid_nxt = 1'b0;
    w_de_nxt    = 1'b0;
    w_data_nxt  = 8'h00;
    w_c_nxt     = 2'b00;
    if (w_state_nxt == LOCKED) begin
      w_valid_nxt = 1'b1;
      if (w_is_ctrl) begin
        w_c_nxt = w_dec_c;
      end else begin
        w_de_nxt   = 1'b1;
        w_data_nxt = w_dec_data;
        w_c_nxt    = r_c;
      end
    end
  end

  // History, offset, saturating counters and registered outputs
  always_ff @(posedge clk_25mhz or negedge rst) begin
    if (!rst) begin
      r_hist     <= '0;
      r_offset   <= 4'd0;
      r_hit_cnt  <= '0;
      r_win_cnt  <= '0;
      r_loss_cnt <= '0;
      r_data     <= 8'h00;
      r_c        <= 2'b00;
      r_de       <= 1'b0;
      r_valid    <= 1'b0;
    end else begin
      r_hist <= {raw_in, r_hist[2*SYM_W-1:SYM_W]};

      if (r_state == SLIP) r_offset <= (r_offset == 4'd9) ? 4'd0 : r_offset + 4'd1;

      if (r_state == SEARCH) begin
        if (!w_is_ctrl)              r_hit_cnt <= '0;
        else if (r_hit_cnt != HIT_MAX) r_hit_cnt <= r_hit_cnt + HIT_W'(1);
        if (r_win_cnt != WIN_LAST)   r_win_cnt <= r_win_cnt + WIN_W'(1);
      end else begin
        r_hit_cnt <= '0;
        r_win_cnt <= '0;
      end

      if ((r_state == LOCKED) && !w_is_ctrl) begin
        if (r_loss_cnt != LOSS_LAST) r_loss_cnt <= r_loss_cnt + LOSS_W'(1);
      end else begin
        r_loss_cnt <= '0;
      end

      r_data  <= w_data_nxt;
      r_c     <= w_c_nxt;
      r_de    <= w_de_nxt;
      r_valid <= w_valid_nxt;
    end
  end

`ifdef TMDS_DECODER_LOSSCNT_EN
  logic [15:0] r_lock_loss_cnt;

  // Count each loss of lock, holding at full scale
  always_ff @(posedge clk_25mhz or negedge rst) begin
    if (!rst) begin
      r_lock_loss_cnt <= 16'd0;
    end else if ((r_state == LOCKED) && (w_state_nxt == SLIP) && (r_lock_loss_cnt != 16'hFFFF)) begin
      r_lock_loss_cnt <= r_lock_loss_cnt + 16'd1;
    end
  end

  assign lock_loss_cnt = r_lock_loss_cnt;
`endif

  assign data   = r_data;
  assign c      = r_c;
  assign de     = r_de;
  assign valid  = r_valid;
  assign locked = (r_state == LOCKED);
  assign offset = r_offset;

endmodule
